// File: rtl/int8_mac_seq.sv
// rtl/int8_mac_seq.sv - job sequencer for the combinational INT8 MAC datapath
//
// Streams N 33-byte operand blocks (byte 0 = scale, bytes 1..32 = elements)
// through an external combinational MAC, one block per cycle. The running
// 24-bit partial sum is held here. The final sum and the first block's scale
// bytes are then offered on a valid/ready result port.
//
// Ports:
//   i_clk, i_rst                  clock, asynchronous active-high reset
//   i_start, i_num_blk, i_abort   job control (start/num_blk sampled in IDLE only)
//   o_busy                        high in RUN or OUT
//   i_in_valid, o_in_ready        operand block handshake
//   i_a_vec_in, i_b_vec_in        operand blocks
//   o_mac_en, o_mac_a, o_mac_b    MAC drive
//   o_mac_psum_in, i_mac_psum_out partial sum to/from MAC
//   o_out_valid, i_out_ready      result handshake
//   o_out_sum, o_out_scale_a/b    result payload
//   o_out_ovf                     accumulator wrapped during job (sticky)
//   o_done                        one-cycle pulse after result handshake
module int8_mac_seq #(
    parameter int BLK_W = 264,
    parameter int ACC_W = 24,
    parameter int LEN_W = 8
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_start,
    input  logic [LEN_W-1:0] i_num_blk,
    input  logic             i_abort,
    output logic             o_busy,
    input  logic             i_in_valid,
    output logic             o_in_ready,
    input  logic [BLK_W-1:0] i_a_vec_in,
    input  logic [BLK_W-1:0] i_b_vec_in,
    output logic             o_mac_en,
    output logic [BLK_W-1:0] o_mac_a,
    output logic [BLK_W-1:0] o_mac_b,
    output logic [ACC_W-1:0] o_mac_psum_in,
    input  logic [ACC_W-1:0] i_mac_psum_out,
    output logic             o_out_valid,
    input  logic             i_out_ready,
    output logic [ACC_W-1:0] o_out_sum,
    output logic [7:0]       o_out_scale_a,
    output logic [7:0]       o_out_scale_b,
    output logic             o_out_ovf,
    output logic             o_done
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_OUT  = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [LEN_W-1:0] r_num;
    logic [LEN_W-1:0] r_cnt;
    logic [ACC_W-1:0] r_acc;
    logic [7:0]       r_scale_a;
    logic [7:0]       r_scale_b;
    logic             r_ovf;
    logic             r_done;

    logic w_first;
    logic w_last;
    logic w_blk_hs;
    logic w_res_hs;
    logic w_job_go;

    assign w_first  = (r_cnt == '0);
    assign w_last   = (r_cnt == r_num - LEN_W'(1));
    // abort outranks both handshakes; the discarded beat must not touch state
    assign w_blk_hs = (r_state == S_RUN) && i_in_valid && !i_abort;
    assign w_res_hs = (r_state == S_OUT) && i_out_ready && !i_abort;
    assign w_job_go = (r_state == S_IDLE) && i_start && !i_abort;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_job_go) begin
                    w_state_nxt = (i_num_blk != '0) ? S_RUN : S_OUT;
                end
            end
            S_RUN: begin
                if (i_abort) begin
                    w_state_nxt = S_IDLE;
                end else if (w_blk_hs && w_last) begin
                    w_state_nxt = S_OUT;
                end
            end
            S_OUT: begin
                if (i_abort || i_out_ready) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_num     <= '0;
            r_cnt     <= '0;
            r_acc     <= '0;
            r_scale_a <= '0;
            r_scale_b <= '0;
            r_ovf     <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_done <= w_res_hs;
            if (w_job_go) begin
                r_cnt <= '0;
                r_acc <= '0;
                r_ovf <= 1'b0;
                if (i_num_blk != '0) begin
                    r_num <= i_num_blk;
                end else begin
                    // empty job reports zero scales; otherwise the first block sets them
                    r_scale_a <= '0;
                    r_scale_b <= '0;
                end
            end
            if (w_blk_hs) begin
                r_acc <= i_mac_psum_out;
                r_cnt <= r_cnt + LEN_W'(1);
                if (w_first) begin
                    r_scale_a <= i_a_vec_in[7:0];
                    r_scale_b <= i_b_vec_in[7:0];
                end else if (i_mac_psum_out < r_acc) begin
                    // each block adds a non-negative term well below 2^24,
                    // so a smaller result can only mean the sum wrapped
                    r_ovf <= 1'b1;
                end
            end
        end
    end

    assign o_busy        = (r_state == S_RUN) || (r_state == S_OUT);
    assign o_in_ready    = (r_state == S_RUN);
    assign o_out_valid   = (r_state == S_OUT);
    assign o_out_sum     = r_acc;
    assign o_out_scale_a = r_scale_a;
    assign o_out_scale_b = r_scale_b;
    assign o_out_ovf     = r_ovf;
    assign o_done        = r_done;

    assign o_mac_a       = i_a_vec_in;
    assign o_mac_b       = i_b_vec_in;
    assign o_mac_en      = (r_state == S_RUN) && !w_first;
    assign o_mac_psum_in = ((r_state == S_RUN) && w_first) ? '0 : r_acc;

endmodule

// File: tb/tb_int8_mac_seq.sv
// tb/tb_int8_mac_seq.sv - directed self-checking bench for int8_mac_seq
module tb_int8_mac_seq;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0;
    logic [7:0]   num_blk = '0;
    logic         abort = 1'b0;
    logic         busy;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [263:0] a_vec = '0;
    logic [263:0] b_vec = '0;
    logic         mac_en;
    logic [263:0] mac_a;
    logic [263:0] mac_b;
    logic [23:0]  mac_psum_in;
    logic [23:0]  mac_psum_out;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [23:0]  out_sum;
    logic [7:0]   out_scale_a;
    logic [7:0]   out_scale_b;
    logic         out_ovf;
    logic         done;

    int n_checks = 0;
    int n_errors = 0;
    int n_done   = 0;

    always #5 clk = ~clk;

    int8_mac_seq #(.BLK_W(264), .ACC_W(24), .LEN_W(8)) dut (
        .i_clk(clk), .i_rst(rst), .i_start(start), .i_num_blk(num_blk),
        .i_abort(abort), .o_busy(busy), .i_in_valid(in_valid),
        .o_in_ready(in_ready), .i_a_vec_in(a_vec), .i_b_vec_in(b_vec),
        .o_mac_en(mac_en), .o_mac_a(mac_a), .o_mac_b(mac_b),
        .o_mac_psum_in(mac_psum_in), .i_mac_psum_out(mac_psum_out),
        .o_out_valid(out_valid), .i_out_ready(out_ready), .o_out_sum(out_sum),
        .o_out_scale_a(out_scale_a), .o_out_scale_b(out_scale_b),
        .o_out_ovf(out_ovf), .o_done(done)
    );

    // MAC model: unsigned dot product of element bytes 1..32, plus psum when enabled
    logic [31:0] mac_tmp;
    always_comb begin
        mac_tmp = mac_en ? {8'd0, mac_psum_in} : 32'd0;
        for (int i = 1; i < 33; i++) begin
            mac_tmp = mac_tmp + 32'(mac_a[8*i +: 8]) * 32'(mac_b[8*i +: 8]);
        end
        mac_psum_out = mac_tmp[23:0];
    end

    always @(negedge clk) begin
        if (done) n_done++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic logic [263:0] make_blk(input logic [7:0] scale, input logic [7:0] elem);
        logic [263:0] v;
        v = '0;
        v[7:0] = scale;
        for (int i = 1; i < 33; i++) v[8*i +: 8] = elem;
        return v;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Runs one job from IDLE through the done pulse. Later blocks carry a
    // different byte 0 so that only the first block may set the scales.
    task automatic run_job(input string tag, input logic [7:0] n,
                           input logic [7:0] sa, input logic [7:0] sb,
                           input logic [7:0] ea, input logic [7:0] eb,
                           input bit gaps, input int stall,
                           input logic [23:0] exp_sum, input bit exp_ovf);
        int sent;
        int cyc;
        start = 1'b1;
        num_blk = n;
        tick();
        start = 1'b0;
        num_blk = 8'h03;
        sent = 0;
        cyc = 0;
        while (sent < int'(n) && cyc < 200) begin
            in_valid = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
            a_vec = make_blk((sent == 0) ? sa : 8'h77, ea);
            b_vec = make_blk((sent == 0) ? sb : 8'h66, eb);
            #1;
            check({tag, ".in_ready"}, 32'(in_ready), 32'd1);
            if (in_valid) begin
                check({tag, ".mac_en"}, 32'(mac_en), (sent != 0) ? 32'd1 : 32'd0);
                if (sent == 0) check({tag, ".psum_in0"}, 32'(mac_psum_in), 32'd0);
            end
            tick();
            if (in_valid) sent++;
            cyc++;
        end
        in_valid = 1'b0;
        check({tag, ".blocks"}, 32'(sent), 32'(n));
        if (!gaps) check({tag, ".latency"}, 32'(out_valid), 32'd1);
        if (n == 0) check({tag, ".no_in_ready"}, 32'(in_ready), 32'd0);
        cyc = 0;
        while (!out_valid && cyc < 10) begin
            tick();
            cyc++;
        end
        for (int s = 0; s < stall; s++) begin
            check({tag, ".stall_valid"}, 32'(out_valid), 32'd1);
            check({tag, ".stall_sum"}, 32'(out_sum), 32'(exp_sum));
            check({tag, ".stall_done"}, 32'(done), 32'd0);
            tick();
        end
        check({tag, ".out_valid"}, 32'(out_valid), 32'd1);
        check({tag, ".sum"}, 32'(out_sum), 32'(exp_sum));
        check({tag, ".scale_a"}, 32'(out_scale_a), (n == 0) ? 32'd0 : 32'(sa));
        check({tag, ".scale_b"}, 32'(out_scale_b), (n == 0) ? 32'd0 : 32'(sb));
        check({tag, ".ovf"}, 32'(out_ovf), 32'(exp_ovf));
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check({tag, ".done"}, 32'(done), 32'd1);
        check({tag, ".idle"}, 32'(busy), 32'd0);
        tick();
        check({tag, ".done_pulse"}, 32'(done), 32'd0);
    endtask

    initial begin
        #1;
        check("rst.busy", 32'(busy), 32'd0);
        check("rst.in_ready", 32'(in_ready), 32'd0);
        check("rst.out_valid", 32'(out_valid), 32'd0);
        check("rst.done", 32'(done), 32'd0);
        check("rst.sum", 32'(out_sum), 32'd0);
        check("rst.mac_en", 32'(mac_en), 32'd0);
        check("rst.psum_in", 32'(mac_psum_in), 32'd0);
        tick();
        tick();
        rst = 1'b0;
        tick();

        // 32 x (1*1)
        run_job("single", 8'd1, 8'h10, 8'h20, 8'h01, 8'h01, 1'b0, 0, 24'd32, 1'b0);
        // 4 x 32 x 255*255
        run_job("multi", 8'd4, 8'h11, 8'h22, 8'hFF, 8'hFF, 1'b0, 0, 24'd8323200, 1'b0);
        // 9 x 2080800 = 18727200 mod 2^24
        run_job("wrap", 8'd9, 8'h01, 8'h02, 8'hFF, 8'hFF, 1'b0, 0, 24'd1949984, 1'b1);
        run_job("bp", 8'd4, 8'h11, 8'h22, 8'hFF, 8'hFF, 1'b1, 5, 24'd8323200, 1'b0);
        run_job("zero", 8'd0, 8'h55, 8'h66, 8'hFF, 8'hFF, 1'b0, 0, 24'd0, 1'b0);

        // abort in IDLE outranks start
        start = 1'b1; abort = 1'b1; num_blk = 8'd4;
        tick();
        start = 1'b0; abort = 1'b0;
        check("idle_abort.busy", 32'(busy), 32'd0);

        // abort after 2 of 4 blocks, with a discarded same-cycle beat
        start = 1'b1; num_blk = 8'd4;
        tick();
        start = 1'b0;
        in_valid = 1'b1;
        a_vec = make_blk(8'h09, 8'h01);
        b_vec = make_blk(8'h09, 8'h01);
        tick();
        tick();
        abort = 1'b1;
        tick();
        abort = 1'b0; in_valid = 1'b0;
        check("abort.busy", 32'(busy), 32'd0);
        check("abort.out_valid", 32'(out_valid), 32'd0);
        check("abort.in_ready", 32'(in_ready), 32'd0);
        tick();
        check("abort.no_done", 32'(done), 32'd0);
        // 32 x (2*2)
        run_job("post_abort", 8'd1, 8'h33, 8'h44, 8'h02, 8'h02, 1'b0, 0, 24'd128, 1'b0);

        // abort while the result is offered, even with out_ready high
        start = 1'b1; num_blk = 8'd0;
        tick();
        start = 1'b0;
        check("out_abort.valid_before", 32'(out_valid), 32'd1);
        abort = 1'b1; out_ready = 1'b1;
        tick();
        abort = 1'b0; out_ready = 1'b0;
        check("out_abort.valid", 32'(out_valid), 32'd0);
        check("out_abort.done", 32'(done), 32'd0);
        tick();
        check("out_abort.no_done", 32'(done), 32'd0);

        // 3 x 32 x (128*2)
        run_job("three", 8'd3, 8'hA5, 8'h5A, 8'h80, 8'h02, 1'b0, 0, 24'd24576, 1'b0);

        // asynchronous reset mid-RUN
        start = 1'b1; num_blk = 8'd4;
        tick();
        start = 1'b0;
        in_valid = 1'b1;
        a_vec = make_blk(8'hC3, 8'h05);
        b_vec = make_blk(8'h3C, 8'h07);
        tick();
        #2;
        rst = 1'b1;
        #1;
        check("arst.busy", 32'(busy), 32'd0);
        check("arst.in_ready", 32'(in_ready), 32'd0);
        check("arst.out_valid", 32'(out_valid), 32'd0);
        check("arst.sum", 32'(out_sum), 32'd0);
        check("arst.scale_a", 32'(out_scale_a), 32'd0);
        check("arst.scale_b", 32'(out_scale_b), 32'd0);
        check("arst.ovf", 32'(out_ovf), 32'd0);
        check("arst.mac_en", 32'(mac_en), 32'd0);
        check("arst.psum_in", 32'(mac_psum_in), 32'd0);
        in_valid = 1'b0;
        tick();
        rst = 1'b0;
        tick();
        check("arst.done", 32'(done), 32'd0);

        check("done_count", 32'(n_done), 32'd7);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
